// File: rtl/digit_selector_if.sv
// Button/load inputs and digit status outputs of the digit selector.
interface digit_selector_if #(
    parameter int unsigned WIDTH = 4
);
    logic             btn_up;
    logic             btn_down;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] digit;
    logic             changed;
    logic             at_min;
    logic             at_max;

    modport master (
        output btn_up, btn_down, load, load_val,
        input  digit, changed, at_min, at_max
    );

    modport slave (
        input  btn_up, btn_down, load, load_val,
        output digit, changed, at_min, at_max
    );
endinterface

// File: rtl/digit_selector.sv
// Up/down digit selector: synchronised, debounced buttons step a bounded digit,
// with a clamped load. Only a rising debounced edge steps, so holding never repeats.
module digit_selector #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned MIN_VAL         = 1,
    parameter int unsigned MAX_VAL         = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned WRAP            = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    digit_selector_if.slave   bus
);
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [WIDTH-1:0] MinV = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MaxV = WIDTH'(MAX_VAL);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    // Bit 0 tracks the up button, bit 1 the down button.
    logic [1:0]       btn_raw;
    logic [1:0]       s1_q, s2_q;
    logic [1:0]       deb_q, deb_d;
    logic [1:0]       prev_q;
    logic [CntW-1:0]  cnt_q [2];
    logic [CntW-1:0]  cnt_d [2];
    logic [WIDTH-1:0] digit_q, digit_d;
    logic             changed_q;
    logic [1:0]       step;
    logic             step_up, step_dn;

    assign btn_raw = {bus.btn_down, bus.btn_up};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (s2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    deb_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    // Simultaneous up and down steps cancel each other.
    assign step    = deb_q & ~prev_q;
    assign step_up = step[0] & ~step[1];
    assign step_dn = step[1] & ~step[0];

    always_comb begin
        digit_d = digit_q;
        if (bus.load) begin
            if (bus.load_val < MinV) begin
                digit_d = MinV;
            end else if (bus.load_val > MaxV) begin
                digit_d = MaxV;
            end else begin
                digit_d = bus.load_val;
            end
        end else if (step_up) begin
            if (digit_q >= MaxV) begin
                digit_d = (WRAP != 0) ? MinV : MaxV;
            end else begin
                digit_d = digit_q + WIDTH'(1);
            end
        end else if (step_dn) begin
            if (digit_q <= MinV) begin
                digit_d = (WRAP != 0) ? MaxV : MinV;
            end else begin
                digit_d = digit_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            deb_q     <= '0;
            prev_q    <= '0;
            cnt_q[0]  <= '0;
            cnt_q[1]  <= '0;
            digit_q   <= MinV;
            changed_q <= 1'b0;
        end else begin
            s1_q      <= btn_raw;
            s2_q      <= s1_q;
            deb_q     <= deb_d;
            prev_q    <= deb_q;
            cnt_q[0]  <= cnt_d[0];
            cnt_q[1]  <= cnt_d[1];
            digit_q   <= digit_d;
            changed_q <= (digit_d != digit_q);
        end
    end

    assign bus.digit   = digit_q;
    assign bus.changed = changed_q;
    assign bus.at_min  = (digit_q == MinV);
    assign bus.at_max  = (digit_q == MaxV);
endmodule
